// File: rtl/core2_dct_pkg.sv
// core2_dct_pkg
// Shared configuration and types for the Core2 OCI data-compressed-trace
// (DCT) packer.
//   FRAG_W : bits per trace fragment
//   FRAGS  : fragments per packed word
//   CNT_W  : width of the fragment-count field (must hold FRAGS)
//   BUF_W  : packed word width (FRAG_W*FRAGS)
//   dct_state_e : packer run-state {RUN, ENDING, ENDED}
package core2_dct_pkg;

  localparam int FRAG_W = 3;
  localparam int FRAGS  = 10;
  localparam int CNT_W  = 4;
  localparam int BUF_W  = FRAG_W * FRAGS;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    ENDING = 2'd1,
    ENDED  = 2'd2
  } dct_state_e;

endpackage

// File: rtl/core2_dct_out_reg.sv
// core2_dct_out_reg
// Single-entry valid/ready holding register for a packed DCT word and its
// fragment count.
// Handshake: a word is transferred to the consumer on a cycle where
// dct_valid && dct_ready; while dct_valid && !dct_ready the word and count
// are held stable. A new word may be loaded whenever the register is empty
// or is being drained in the same cycle (can_load).
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   load                  : capture load_buf/load_cnt this cycle
//   load_buf, load_cnt    : word and count to capture
//   dct_ready             : consumer ready
//   dct_buffer, dct_count : registered word and count
//   dct_valid             : registered word-available flag
//   can_load              : combinational, register free for a load
module core2_dct_out_reg #(
  parameter int BUF_W = core2_dct_pkg::BUF_W,
  parameter int CNT_W = core2_dct_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [BUF_W-1:0] load_buf,
  input  logic [CNT_W-1:0] load_cnt,
  input  logic             dct_ready,
  output logic [BUF_W-1:0] dct_buffer,
  output logic [CNT_W-1:0] dct_count,
  output logic             dct_valid,
  output logic             can_load
);

  logic [BUF_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;

  always_comb begin
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    can_load = !valid_q || dct_ready;
    if (load && can_load) begin
      buf_d   = load_buf;
      cnt_d   = load_cnt;
      valid_d = 1'b1;
    end else if (valid_q && dct_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign dct_buffer = buf_q;
  assign dct_count  = cnt_q;
  assign dct_valid  = valid_q;

endmodule

// File: rtl/core2_cpu_1_oci_dct_packer.sv
// core2_cpu_1_oci_dct_packer
// Producer side of the Core2 OCI DCT interface. Packs FRAG_W-bit trace
// fragments into BUF_W-bit words (fragment i at bits [FRAG_W*i +: FRAG_W],
// fragment 0 at the LSB), hands them to the consumer through a single-entry
// output register, and sequences the end-of-run signals.
// Handshakes (both sides): a transfer happens on a rising edge where
// valid && ready are both high; the offering side holds its data stable
// until then.
// Optional feature: define CORE2_DCT_DROP_EN to make frag_ready constantly
// high in RUN; fragments that cannot be stored are then discarded and the
// sticky dct_overflow flag is raised. Without it, back-pressure is applied
// and dct_overflow is tied low.
// Ports:
//   clk, reset_n             : clock, asynchronous active-low reset
//   frag_valid/ready/data    : fragment input handshake
//   flush                    : pulse, emit the partial word
//   end_req                  : pulse, end the trace run
//   dct_buffer/count/valid   : packed word output, dct_ready from consumer
//   test_ending              : high in ENDING
//   test_has_ended           : high in ENDED (sticky until reset)
//   dct_overflow             : sticky drop flag
//   dbg_state                : current run-state, for observation
module core2_cpu_1_oci_dct_packer #(
  parameter int FRAG_W = core2_dct_pkg::FRAG_W,
  parameter int FRAGS  = core2_dct_pkg::FRAGS,
  parameter int CNT_W  = core2_dct_pkg::CNT_W
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      frag_valid,
  input  logic [FRAG_W-1:0]         frag_data,
  output logic                      frag_ready,
  input  logic                      flush,
  input  logic                      end_req,
  output logic [FRAG_W*FRAGS-1:0]   dct_buffer,
  output logic [CNT_W-1:0]          dct_count,
  output logic                      dct_valid,
  input  logic                      dct_ready,
  output logic                      test_ending,
  output logic                      test_has_ended,
  output logic                      dct_overflow,
  output logic [1:0]                dbg_state
);

  import core2_dct_pkg::*;

  localparam int W = FRAG_W * FRAGS;

  dct_state_e       state_q, state_d;
  logic [W-1:0]     fill_data_q, fill_data_d;
  logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
  logic             flush_pend_q, flush_pend_d;

  logic             full;
  logic             can_load;
  logic             in_run;
  logic             frag_take;
  logic             flush_req;
  logic             flush_cond;
  logic [W-1:0]     m_data;
  logic [CNT_W-1:0] m_cnt;
  logic             xfer;

  always_comb begin
    state_d      = state_q;
    fill_data_d  = fill_data_q;
    fill_cnt_d   = fill_cnt_q;
    flush_pend_d = flush_pend_q;

    full      = (fill_cnt_q == CNT_W'(FRAGS));
    in_run    = (state_q == RUN);
    // A fragment can be stored unless the fill register is full and the
    // output register cannot take the full word this cycle.
    frag_take = frag_valid && in_run && !(full && !can_load);
`ifdef CORE2_DCT_DROP_EN
    frag_ready = in_run;
`else
    frag_ready = in_run && !(full && !can_load);
`endif

    flush_req  = flush && (state_q != ENDED);
    flush_cond = flush_pend_q || flush_req || (state_q == ENDING);

    // Merge an arriving fragment into the current fill so it can leave in
    // the same cycle's transfer. When full, the register is moved as-is and
    // the fragment starts the next word instead.
    m_data = fill_data_q;
    m_cnt  = fill_cnt_q;
    if (!full && frag_take) begin
      for (int i = 0; i < FRAGS; i++) begin
        if (fill_cnt_q == CNT_W'(i)) m_data[i*FRAG_W +: FRAG_W] = frag_data;
      end
      m_cnt = fill_cnt_q + CNT_W'(1);
    end

    if (full) xfer = can_load;
    else      xfer = can_load && ((m_cnt == CNT_W'(FRAGS)) ||
                                  (flush_cond && (m_cnt != '0)));

    if (xfer) begin
      if (full && frag_take) begin
        fill_data_d = W'(frag_data);
        fill_cnt_d  = CNT_W'(1);
      end else begin
        fill_data_d = '0;
        fill_cnt_d  = '0;
      end
    end else begin
      fill_data_d = m_data;
      fill_cnt_d  = m_cnt;
    end

    // A flush that finds the output register occupied waits for the
    // transfer; an empty flush leaves nothing behind.
    if ((state_q == ENDED) || xfer)         flush_pend_d = 1'b0;
    else if (flush_req && (m_cnt != '0))    flush_pend_d = 1'b1;

    case (state_q)
      RUN:    if (end_req) state_d = ENDING;
      ENDING: if ((fill_cnt_q == '0) && (!dct_valid || dct_ready))
                state_d = ENDED;
      ENDED:  state_d = ENDED;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= RUN;
      fill_data_q  <= '0;
      fill_cnt_q   <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fill_data_q  <= fill_data_d;
      fill_cnt_q   <= fill_cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

`ifdef CORE2_DCT_DROP_EN
  logic overflow_q, overflow_d;

  always_comb begin
    overflow_d = overflow_q;
    if (frag_valid && in_run && full && !can_load) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) overflow_q <= 1'b0;
    else          overflow_q <= overflow_d;
  end

  assign dct_overflow = overflow_q;
`else
  assign dct_overflow = 1'b0;
`endif

  core2_dct_out_reg #(
    .BUF_W (W),
    .CNT_W (CNT_W)
  ) u_out_reg (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (xfer),
    .load_buf   (m_data),
    .load_cnt   (m_cnt),
    .dct_ready  (dct_ready),
    .dct_buffer (dct_buffer),
    .dct_count  (dct_count),
    .dct_valid  (dct_valid),
    .can_load   (can_load)
  );

  assign test_ending    = (state_q == ENDING);
  assign test_has_ended = (state_q == ENDED);
  assign dbg_state      = state_q;

endmodule

// File: doc/core2_cpu_1_oci_dct_packer.md
# core2_cpu_1_oci_dct_packer

Producer side of the Core2 OCI data-compressed-trace (DCT) interface. Packs 3-bit trace fragments from the CPU trace logic into 30-bit `dct_buffer` words with an occupancy count `dct_count`, and presents them to the DCT consumer through a valid/ready handshake. It also generates the `test_ending` / `test_has_ended` end-of-run signals that the OCI test bench samples. It sits between the trace fragment source and the OCI test bench / trace sink.

## Interface
Parameters:
- `FRAG_W`, 3: bits per trace fragment.
- `FRAGS`, 10: fragments per word. Buffer width is `FRAG_W*FRAGS` = 30.
- `CNT_W`, 4: width of `dct_count`. Must hold the value `FRAGS`.

Ports:
- `clk`  in  1: single clock; all logic is rising-edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `frag_valid`  in  1: fragment offered.
- `frag_data`  in  3: fragment value.
- `frag_ready`  out  1: fragment accepted when `frag_valid && frag_ready`.
- `flush`  in  1: single-cycle request to emit a partial word.
- `end_req`  in  1: single-cycle request to end the trace run.
- `dct_buffer`  out  30: packed word. Fragment i occupies bits [3i+2:3i]; fragment 0 is at the LSB.
- `dct_count`  out  4: number of valid fragments in `dct_buffer` (1..10 while `dct_valid`).
- `dct_valid`  out  1: word available.
- `dct_ready`  in  1: consumer accepts the word when `dct_valid && dct_ready`.
- `test_ending`  out  1: high throughout the ENDING state.
- `test_has_ended`  out  1: sticky; high in the ENDED state.
- `dct_overflow`  out  1: sticky drop flag (see Configuration).

## Operation
- **Fill register.** Holds up to 10 fragments and a fill count. Each accepted fragment is written at slot `fill_cnt`, then the count increments.
- **Transfer to output.** The fill register moves to the single-entry output register when either:
  - it holds 10 fragments, or
  - a flush or end condition is pending and it holds at least 1 fragment.
  
  The transfer happens only if the output register is empty or is being drained that cycle. After a transfer, `fill_cnt` = 0 and the fill data is cleared. Unused slots of a partial word read as 0.
- **Fragment plus transfer in the same cycle.** The incoming fragment is included in the transferred word.
- **`frag_ready`.** Equals `!(fill_cnt==10 && dct_valid && !dct_ready)` in RUN, and is 0 in ENDING and ENDED.
- **Flush.**
  - A `flush` with `fill_cnt==0` and no fragment arriving is a no-op.
  - A flush blocked by an occupied output register stays pending until the transfer happens.
- **State machine.**
  - RUN → ENDING when `end_req` is sampled. A fragment accepted in that same cycle is kept.
  - ENDING: forces a flush. Goes to ENDED once `fill_cnt==0` and the output register is empty (or is handshaking that cycle). ENDING lasts at least 1 cycle.
  - ENDED is terminal until reset. `end_req` is ignored in ENDING and ENDED; `flush` is ignored in ENDED.
- **Reset (asynchronous, any time, including mid-word or mid-handshake).**
  - Outputs: `dct_buffer`=0, `dct_count`=0, `dct_valid`=0, `frag_ready`=1, `test_ending`=0, `test_has_ended`=0, `dct_overflow`=0.
  - Internal: state = RUN, `fill_cnt`=0.
  - Any pending word is discarded.

## Timing
- Latency: the 10th fragment is accepted at edge N; `dct_valid` is high after edge N.
- Throughput: 1 fragment per cycle sustained while `dct_ready` is held high. No bubble at the word boundary.
- `dct_buffer`, `dct_count` and `dct_valid` are registered. They are stable while `dct_valid && !dct_ready`.
- `frag_ready` is combinational from `dct_ready` and registered state.
- `test_ending` and `test_has_ended` are registered, and are never high together.

## Configuration
- Macro: `CORE2_DCT_DROP_EN`.
- **Defined:**
  - `frag_ready` is 1 in RUN.
  - A fragment arriving while the fill register is full and the output register cannot drain is discarded, and `dct_overflow` is set. It stays set until reset.
- **Undefined:**
  - Back-pressure applies as specified in Operation.
  - `dct_overflow` is tied to 0.

## Structure
- Shared package `core2_dct_pkg` holds:
  - `FRAG_W`, `FRAGS`, `CNT_W`, and derived `BUF_W`=30;
  - the state typedef {RUN, ENDING, ENDED}.
- One sub-module, `core2_dct_out_reg`: the single-entry valid/ready holding register for buffer and count. The top level contains the fill register, counter and state machine.

## Test plan
- **Ten fragments.** Feed 10 fragments 0..7,0,1 back-to-back with `dct_ready`=1 → one word: `dct_buffer`=30'o1076543210, `dct_count`=10, `dct_valid` for 1 cycle, 1 cycle after the 10th fragment.
- **Flush of a partial word.** Feed 3 fragments 5,5,5 then pulse `flush` → `dct_buffer`=30'o555, `dct_count`=3. A `flush` with the fill register empty → no word emitted.
- **Back-pressure.** Hold `dct_ready`=0 and feed 25 fragments → after 20 accepted, `frag_ready`=0 and the first word is held stable. Release `dct_ready` → 3 words with counts 10, 10, then 5 after a flush.
- **End of run.** Feed 4 fragments, pulse `end_req` → `test_ending` high until the count-4 word handshakes, then `test_has_ended`=1 and stays high. Later `frag_valid` is not accepted.
- **Reset mid-operation.** Assert `reset_n`=0 with `dct_valid`=1 and 6 fragments pending → all outputs reach reset values immediately. After release, the first word contains only new fragments.
- **Overflow (`CORE2_DCT_DROP_EN` defined).** Stall as in the back-pressure scenario → the 21st fragment is dropped and `dct_overflow`=1. Without the macro, `dct_overflow` stays 0.
